// File: rtl/saradc_sar_ctrl.sv
// SAR conversion controller: drives SAMPLE/VALID for the logic buffer, turns latched
// comparator decisions into per-bit switch settings and assembles the output code.
module saradc_sar_ctrl #(
  parameter int NBITS         = 8,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             CONT,
  input  logic             CMPP,
  input  logic             CMPN,
  output logic             SAMPLE,
  output logic             VALID,
  output logic [NBITS-1:1] RESULTP,
  output logic [NBITS-1:1] RESULTN,
  output logic [NBITS-1:0] DOUT,
  output logic             ERR,
  output logic             BUSY
);

  localparam int CW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int KW = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SMP  = 2'd1;
  localparam logic [1:0] CONV = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] smpCnt;
  logic [KW-1:0] bitIdx;
  logic          errAcc;
  logic          cmpBad;
  logic          startReq;

  assign cmpBad   = (CMPP == CMPN);
  assign startReq = START | CONT;

  // RESULTP doubles as the upper code bits, so DOUT is just RESULTP plus the final decision.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      smpCnt  <= '0;
      bitIdx  <= '0;
      errAcc  <= 1'b0;
      SAMPLE  <= 1'b0;
      VALID   <= 1'b0;
      RESULTP <= '0;
      RESULTN <= '0;
      DOUT    <= '0;
      ERR     <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          VALID <= 1'b0;
          if (startReq) begin
            state   <= SMP;
            SAMPLE  <= 1'b1;
            BUSY    <= 1'b1;
            RESULTP <= '0;
            RESULTN <= '0;
            ERR     <= 1'b0;
            errAcc  <= 1'b0;
            smpCnt  <= CW'(SAMPLE_CYCLES - 1);
          end else begin
            state <= IDLE;
          end
        end
        SMP: begin
          if (smpCnt != '0) begin
            smpCnt <= smpCnt - 1'b1;
          end else begin
            state  <= CONV;
            SAMPLE <= 1'b0;
            bitIdx <= KW'(NBITS - 1);
          end
        end
        CONV: begin
          // A tied comparator is flagged but its CMPP decision is still used.
          errAcc <= errAcc | cmpBad;
          if (bitIdx != '0) begin
            RESULTP[bitIdx] <= CMPP;
            RESULTN[bitIdx] <= ~CMPP;
            bitIdx          <= bitIdx - 1'b1;
          end else begin
            state <= DONE;
            VALID <= 1'b1;
            BUSY  <= 1'b0;
            DOUT  <= {RESULTP, CMPP};
            ERR   <= errAcc | cmpBad;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
